if_id_buffer: RTL and testbench

- Two-entry fetch buffer forming the IF/ID boundary between the fetch stage (PC register + instruction memory) and the decode stage.
- Captures the {PC, Instruction} pair presented combinationally by fetch and drives the fetch PCWrite enable (back-pressure).
- Presents the oldest entry to decode with a valid flag, and discards wrong-path instructions on a taken branch.
- Keeps a saturating count of stall cycles for performance debug.

---
 rtl/if_id_buffer_if.sv | 28 ++
 rtl/if_id_buffer.sv | 80 ++++++++
 tb/tb_if_id_buffer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/if_id_buffer_if.sv
// IF/ID boundary bundle: fetch pair, redirect, back-pressure, decode head.
// master = fetch/decode side, slave = the buffer.
`timescale 1ns/1ps
interface if_id_buffer_if #(
  parameter int PC_WIDTH   = 12,
  parameter int INST_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic [PC_WIDTH-1:0]   if_pc;
  logic [INST_WIDTH-1:0] if_inst;
  logic                  branch;
  logic                  PCWrite;
  logic                  id_stall;
  logic                  id_valid;
  logic [PC_WIDTH-1:0]   id_pc;
  logic [INST_WIDTH-1:0] id_inst;
  logic [CNT_WIDTH-1:0]  stall_cnt;

  modport master (
    output if_pc, if_inst, branch, id_stall,
    input  PCWrite, id_valid, id_pc, id_inst, stall_cnt
  );

  modport slave (
    input  if_pc, if_inst, branch, id_stall,
    output PCWrite, id_valid, id_pc, id_inst, stall_cnt
  );
endinterface

// File: rtl/if_id_buffer.sv
// Two-entry IF/ID fetch buffer with branch flush and stall counter.
// Ports: clk, rst (async active-low), bus (slave: fetch in, decode out).
`timescale 1ns/1ps
module if_id_buffer #(
  parameter int PC_WIDTH   = 12,
  parameter int INST_WIDTH = 32,
  parameter logic [INST_WIDTH-1:0] NOP_INST = 32'h00000013,
  parameter int CNT_WIDTH  = 16
) (
  input logic clk,
  input logic rst,
  if_id_buffer_if.slave bus
);

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0] inst;
  } entry_t;

  entry_t               mem [2];
  entry_t               head_e;
  logic                 head;
  logic                 tail;
  logic [1:0]           count;
  logic [CNT_WIDTH-1:0] stall_q;

  logic valid;
  logic full;
  logic pc_write;
  logic enq;
  logic deq;

  assign valid    = count != 2'd0;
  assign full     = count == 2'd2;
  // Only registers and branch feed PCWrite; id_stall stays out of it.
  assign pc_write = ~full | bus.branch;
  assign enq      = pc_write & ~bus.branch;
  assign deq      = valid & ~bus.id_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else if (bus.branch) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (enq) tail <= ~tail;
      if (deq) head <= ~head;
      unique case (1'b1)
        (enq & ~deq): count <= count + 2'd1;
        (deq & ~enq): count <= count - 2'd1;
        default:      count <= count;
      endcase
    end
  end

  // Entry payload needs no reset: count gates visibility.
  always_ff @(posedge clk) begin
    if (enq) mem[tail] <= {bus.if_pc, bus.if_inst};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (full & ~bus.branch & ~(&stall_q)) begin
      stall_q <= stall_q + CNT_WIDTH'(1);
    end
  end

  assign head_e        = mem[head];
  assign bus.PCWrite   = pc_write;
  assign bus.id_valid  = valid;
  assign bus.id_pc     = valid ? head_e.pc : '0;
  assign bus.id_inst   = valid ? head_e.inst : NOP_INST;
  assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: directed flow, stall, flush, reset.
// A fetch model drives PC/inst; a monitor checks every decode handshake.
`timescale 1ns/1ps
module tb_if_id_buffer;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [11:0] fpc;
  logic [11:0] tgt;
  logic [11:0] exp_pc;
  logic [11:0] sb [$];
  int checks = 0;
  int errors = 0;

  if_id_buffer_if bus ();

  if_id_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(logic [11:0] pc);
    return {8'hA5, 12'h000, pc};
  endfunction

  // Fetch stage: PC register updated by PCWrite, muxed by branch.
  always @(posedge clk or negedge rst) begin
    if (!rst) fpc <= '0;
    else if (bus.PCWrite) fpc <= bus.branch ? tgt : fpc + 12'd4;
  end

  assign bus.if_pc   = fpc;
  assign bus.if_inst = inst_of(fpc);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a handshake at this negedge means a dequeue at the next edge.
  always @(negedge clk) begin
    if (rst && !bus.branch && bus.id_valid && !bus.id_stall) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL deq_extra: got pc %0h expected none", bus.id_pc);
      end else begin
        exp_pc = sb.pop_front();
        chk("deq_pc", 32'(bus.id_pc), 32'(exp_pc));
        chk("deq_inst", bus.id_inst, inst_of(exp_pc));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.branch   = 1'b0;
    bus.id_stall = 1'b0;
    tgt          = 12'h100;
    sb.push_back(12'h000);
    sb.push_back(12'h004);
    sb.push_back(12'h008);
    sb.push_back(12'h00C);

    step();
    chk("rst_valid", 32'(bus.id_valid), 0);
    chk("rst_pc", 32'(bus.id_pc), 0);
    chk("rst_inst", bus.id_inst, NOP);
    chk("rst_pcwrite", 32'(bus.PCWrite), 1);
    chk("rst_cnt", 32'(bus.stall_cnt), 0);
    rst = 1'b1;
    #1;
    chk("c0_valid", 32'(bus.id_valid), 0);

    step();
    chk("c1_pc", 32'(bus.id_pc), 32'h000);
    chk("c1_pcwrite", 32'(bus.PCWrite), 1);
    step();
    chk("c2_pc", 32'(bus.id_pc), 32'h004);
    chk("c2_pcwrite", 32'(bus.PCWrite), 1);
    step();
    chk("c3_pc", 32'(bus.id_pc), 32'h008);
    bus.id_stall = 1'b1;

    step();
    chk("full_pcwrite", 32'(bus.PCWrite), 0);
    chk("full_head", 32'(bus.id_pc), 32'h008);
    step();
    step();
    step();
    chk("stall_cnt3", 32'(bus.stall_cnt), 3);

    step();
    bus.id_stall = 1'b0;
    chk("c8_pc", 32'(bus.id_pc), 32'h008);
    step();
    chk("c9_pcwrite", 32'(bus.PCWrite), 1);
    chk("c9_pc", 32'(bus.id_pc), 32'h00C);
    step();
    chk("c10_pc", 32'(bus.id_pc), 32'h010);
    bus.id_stall = 1'b1;

    step();
    chk("c11_pcwrite", 32'(bus.PCWrite), 0);
    chk("c11_pc", 32'(bus.id_pc), 32'h010);
    bus.branch   = 1'b1;
    bus.id_stall = 1'b0;
    #1;
    chk("br_pcwrite", 32'(bus.PCWrite), 1);

    step();
    bus.branch = 1'b0;
    chk("flush_valid", 32'(bus.id_valid), 0);
    chk("flush_inst", bus.id_inst, NOP);
    chk("flush_pc", 32'(bus.id_pc), 0);
    chk("flush_cnt", 32'(bus.stall_cnt), 5);
    for (int i = 0; i < 12; i++) sb.push_back(12'h100 + 12'(4 * i));

    step();
    chk("tgt_pc", 32'(bus.id_pc), 32'h100);
    step();
    chk("c14_pc", 32'(bus.id_pc), 32'h104);
    chk("c14_valid", 32'(bus.id_valid), 1);

    for (int i = 0; i < 20; i++) begin
      step();
      bus.id_stall = (i % 2 == 0);
    end

    step();
    bus.id_stall = 1'b1;
    chk("c35_pc", 32'(bus.id_pc), 32'h130);
    step();
    chk("c36_pcwrite", 32'(bus.PCWrite), 0);
    chk("c36_cnt", 32'(bus.stall_cnt), 15);
    chk("sb_drained", sb.size(), 0);

    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.id_valid), 0);
    chk("arst_pc", 32'(bus.id_pc), 0);
    chk("arst_inst", bus.id_inst, NOP);
    chk("arst_pcwrite", 32'(bus.PCWrite), 1);
    chk("arst_cnt", 32'(bus.stall_cnt), 0);

    step();
    rst = 1'b1;
    step();
    step();
    chk("sat_full", 32'(bus.PCWrite), 0);
    chk("sat_c0", 32'(bus.stall_cnt), 0);
    repeat (1000) step();
    chk("sat_c1000", 32'(bus.stall_cnt), 1000);
    repeat (64534) step();
    chk("sat_fffe", 32'(bus.stall_cnt), 32'hFFFE);
    step();
    chk("sat_ffff", 32'(bus.stall_cnt), 32'hFFFF);
    repeat (5) step();
    chk("sat_hold", 32'(bus.stall_cnt), 32'hFFFF);
    chk("sat_pc", 32'(bus.id_pc), 0);
    chk("sat_inst", bus.id_inst, inst_of(12'h000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
